// File: rtl/vram_line_prefetch_if.sv
// vram_line_prefetch_if: timing strobes, pixel read port and memory read port of the line prefetcher
interface vram_line_prefetch_if;
   logic        line_start;
   logic        line_bank;
   logic [7:0]  line_row;
   logic        vid_swap;
   logic [4:0]  vid_addr;
   logic [15:0] vid_data;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        busy;
   logic        underrun;
   modport master (
      output line_start, line_bank, line_row, vid_swap, vid_addr, mem_ack, mem_data,
      input  vid_data, mem_req, mem_addr, busy, underrun
   );
   modport slave (
      input  line_start, line_bank, line_row, vid_swap, vid_addr, mem_ack, mem_data,
      output vid_data, mem_req, mem_addr, busy, underrun
   );
endinterface

// File: rtl/vram_line_prefetch.sv
// vram_line_prefetch: double-buffered scanline prefetcher feeding the video pixel shifter
module vram_line_prefetch #(
   parameter logic [15:0] BANK0_BASE = 16'h2000,
   parameter logic [15:0] BANK1_BASE = 16'hE000
) (
   input logic clk_sys,
   input logic reset,
   vram_line_prefetch_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
   state_t      state, state_nx;
   logic [15:0] line_buf [2][32];
   logic [15:0] base, vid_q;
   logic [7:0]  row;
   logic [4:0]  idx;
   logic        disp_sel, underrun_q, underrun_nx, fill_valid, take, swap_ok;
   assign bus.mem_req  = state == FETCH;
   assign bus.busy     = state == FETCH;
   assign bus.mem_addr = base + {3'd0, row, idx};
   assign bus.vid_data = vid_q;
   assign bus.underrun = underrun_q;
   // next state: a new line always wins, then a good swap, then the final ack
   always_comb begin
      fill_valid  = state == DONE;
      take        = state == FETCH && bus.mem_ack;
      swap_ok     = bus.vid_swap && fill_valid;
      underrun_nx = (bus.vid_swap && !fill_valid) || (bus.line_start && state == FETCH);
      state_nx    = bus.line_start ? FETCH : swap_ok ? IDLE : (take && idx == 5'd31) ? DONE : state;
   end
   // control registers; the swap uses pre-edge fill_valid so a coincident line_start fills the new back buffer
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         disp_sel   <= 1'b0;
         idx        <= 5'd0;
         base       <= BANK0_BASE;
         row        <= 8'd0;
         underrun_q <= 1'b0;
         vid_q      <= 16'd0;
      end else begin
         state      <= state_nx;
         underrun_q <= underrun_nx;
         vid_q      <= line_buf[disp_sel][bus.vid_addr];
         if (swap_ok) disp_sel <= ~disp_sel;
         if (bus.line_start) begin
            base <= bus.line_bank ? BANK1_BASE : BANK0_BASE;
            row  <= bus.line_row;
            idx  <= 5'd0;
         end else if (take && idx != 5'd31) begin
            idx <= idx + 5'd1;
         end
      end
   end
   // back-buffer write; an ack arriving during reset is dropped
   always_ff @(posedge clk_sys) begin
      if (take && !reset) line_buf[~disp_sel][idx] <= bus.mem_data;
   end
endmodule

// File: doc/vram_line_prefetch.md
# vram_line_prefetch

Double-buffered scanline prefetcher between the shared system memory and the video stage. During the current line, it fetches the 32 screen words for the next scanline from main memory over a request/acknowledge port. It then serves those words to the video pixel shifter through a single-cycle read port, so video fetches never contend with CPU memory cycles. Row, bank and buffer-swap events come from the video timing generator.

## Interface
Parameters:
- BANK0_BASE, 16'h2000, word address of screen page used when bank=0.
- BANK1_BASE, 16'hE000, word address of screen page used when bank=1.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- line_start  in  1  one-cycle strobe: begin fetching a new line.
- line_bank  in  1  screen bank for the line; sampled on line_start.
- line_row  in  8  row number (scroll already applied); sampled on line_start.
- vid_swap  in  1  one-cycle strobe at line boundary: display the freshly filled buffer.
- vid_addr  in  5  word index within the displayed line.
- vid_data  out  16  displayed word at vid_addr, registered.
- mem_req  out  1  memory read request, level.
- mem_addr  out  16  word address of the current request.
- mem_ack  in  1  one-cycle pulse; mem_data valid in the same cycle.
- mem_data  in  16  read data.
- busy  out  1  high while a fill is in progress.
- underrun  out  1  one-cycle pulse on a failed swap or an aborted fill.

## Operation
- Storage is two 32x16 buffers. disp_sel selects the displayed buffer; the fill buffer is always ~disp_sel.
- FSM states:
  - IDLE: mem_req=0.
  - FETCH: mem_req=1.
  - DONE: mem_req=0, fill_valid=1.
- On line_start in any state:
  - latch base = line_bank ? BANK1_BASE : BANK0_BASE and row = line_row
  - set idx=0 and fill_valid=0, then go to FETCH
  - if the FSM was in FETCH, pulse underrun (aborted fill).
- Address: mem_addr = base + {row, idx}. The sum is 16 bits and wraps modulo 2^16 with no carry out.
- In FETCH, on mem_ack:
  - write mem_data to fill[idx]
  - if idx==31, go to DONE; otherwise idx++ and stay in FETCH.
- mem_req is held high through consecutive words. mem_addr updates the cycle after each ack. A back-to-back ack in that cycle is legal and applies to the new address.
- vid_swap:
  - If fill_valid=1: toggle disp_sel, clear fill_valid, go to IDLE.
  - Otherwise: no toggle, pulse underrun. The display keeps showing the old line.
- Simultaneous vid_swap and line_start: the swap is evaluated first, using the pre-edge fill_valid. The new fill then targets the new ~disp_sel. No underrun is raised for that swap if fill_valid was 1.
- mem_ack outside FETCH is ignored; no buffer write occurs.
- busy = (state==FETCH).

## Timing
- Reset values:
  - state=IDLE, disp_sel=0, fill_valid=0, idx=0
  - mem_req=0, mem_addr=BANK0_BASE, busy=0, underrun=0, vid_data=0.
- Buffer contents are undefined after reset.
- line_start in cycle N gives mem_req=1 with the first address in cycle N+1.
- Minimum fill time, with ack every cycle: first ack in N+1, last ack in N+32, DONE in N+33.
- vid_data is valid one cycle after vid_addr is presented. It reflects disp_sel as of the cycle the address was sampled.
- A vid_swap in cycle M affects reads addressed from M+1 onward.
- Reset mid-fill drops mem_req in the next cycle; any ack in that cycle is ignored.
- underrun is exactly one cycle wide per event.

## Test plan
- Nominal fill:
  - Stimulus: reset, then line_start with bank=0, row=8'h05; ack every cycle with mem_data=addr^16'hA5A5.
  - Required: 32 requests at addresses 16'h20A0..16'h20BF; DONE at N+33.
  - After vid_swap, vid_addr=3 returns 16'h20A3^16'hA5A5 one cycle later.
- Bank and wrap:
  - Stimulus: bank=1, row=8'hFF.
  - Required: addresses run 16'hFFE0..16'hFFFF, then hold; no carry out; the last ack writes fill[31].
- Throttled memory:
  - Stimulus: ack every 4th cycle.
  - Required: mem_req stays high continuously; each address is held until acked; fill completes with 32 words correct.
- Late fill:
  - Stimulus: vid_swap while busy.
  - Required: underrun pulses once; disp_sel is unchanged; vid_data still returns the prior line's words.
  - A later vid_swap after DONE toggles disp_sel.
- Abort and simultaneity:
  - Stimulus: line_start at idx=10.
  - Required: underrun pulses; idx restarts at 0 with the new base.
  - Stimulus: vid_swap and line_start in the same cycle with fill_valid=1.
  - Required: swap occurs, no underrun, and the new fill writes the other buffer.
- Reset mid-operation:
  - Stimulus: reset at idx=20.
  - Required: mem_req=0 next cycle, busy=0, disp_sel=0, vid_data=0.
